seg_scan_buffer: RTL
====================

SEG_SCAN_BUFFER -- requirements
Module: seg_scan_buffer

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed display digits (2..8).
REQ-002 SHALL have parameter SYSCLK_F, default 24000000: sys_clk frequency in Hz.
REQ-003 SHALL have parameter SCAN_HZ, default 800: full-display refresh rate; DWELL_CYC = SYSCLK_F / (SCAN_HZ * DIGITS) cycles per digit, integer division, DWELL_CYC >= 2.
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_data  input  8  ASCII byte from the UART receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port segments  output  8  pattern for the downstream shift driver; bit0=a .. bit6=g, bit7=dp, active-high.
REQ-009 SHALL have port digit_sel  output  DIGITS  one-hot enable of the digit being presented.
REQ-010 SHALL have port out_valid  output  1  segments/digit_sel hold a new digit.
REQ-011 SHALL have port out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port overrun  output  1  sticky flag: a dwell expired while a presentation was still pending.

Function
REQ-013 SHALL keep a DIGITS-entry buffer; each entry holds {used, nibble[3:0], dp}; index 0 is the rightmost digit.
REQ-014 On rx_valid with '0'-'9', 'A'-'F' or 'a'-'f', SHALL shift entries up by one (entry DIGITS-1 dropped) and write {1, value, 0} to entry 0, effective the next cycle.
REQ-015 On rx_valid with '.' (0x2E), SHALL set dp of entry 0 and leave all other fields unchanged.
REQ-016 On rx_valid with CR (0x0D), SHALL clear every entry to {0,0,0}.
REQ-017 SHALL ignore every other byte value.
REQ-018 Decode: used=0 -> 0x00 (blank, dp still applied); 0..F -> 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71; dp ORs in bit7.
REQ-019 SHALL run a dwell counter 0..DWELL_CYC-1 that wraps freely and is never stalled.
REQ-020 Scanner FSM states SCAN and PRESENT; reset enters SCAN.
REQ-021 In SCAN, at dwell wrap: advance the digit index (DIGITS-1 wraps to 0); register the decoded pattern and one-hot digit_sel; assert out_valid; enter PRESENT.
REQ-022 In PRESENT, segments/digit_sel/out_valid SHALL stay stable until out_ready; on the transfer, deassert out_valid the next cycle and return to SCAN.
REQ-023 A dwell wrap while in PRESENT SHALL set overrun and SHALL NOT advance the index or change the outputs.
REQ-024 A transfer and a dwell wrap in the same cycle SHALL count as on time: no overrun; the next digit is loaded and the FSM stays in PRESENT.
REQ-025 If a buffer write and a presentation load fall in the same cycle, the load SHALL use the pre-write buffer contents.
REQ-026 Latency: byte to buffer is 1 cycle; a buffer change is shown no later than the next presentation of that digit.

Reset
REQ-027 On rst: segments=0x00, digit_sel=0, out_valid=0, overrun=0, dwell counter=0, digit index=DIGITS-1 (so the first presentation is digit 0), all buffer entries {0,0,0}, FSM=SCAN.
REQ-028 rst asserted mid-presentation SHALL drop out_valid on the next edge, regardless of out_ready.

Structure
REQ-029 Package seg_pkg SHALL hold: the segment bit positions, the 16-entry hex decode table, BLANK=0x00, and ASCII constants CR=0x0D and DOT=0x2E.
REQ-030 The combinational decoder SHALL be the sub-module hex_to_seg: inputs used, nibble, dp; output 8-bit pattern. No other sub-modules.

Verification
Benches use SYSCLK_F=1600, SCAN_HZ=100, DIGITS=4, giving DWELL_CYC=4.
REQ-031 Reset, out_ready tied high -> first out_valid 4 cycles after rst release with digit_sel=0001 and segments=0x00; then 0010, 0100, 1000, 0001, each 4 cycles apart.
REQ-032 Send "1", "2", ".", "A" -> digit 0 = 0x77, digit 1 = 0xDB, digit 2 = 0x06, digit 3 = 0x00.
REQ-033 Buffer loaded, then CR -> all digits present 0x00 from the next presentation of each digit; bytes 'G' and 0x20 -> no change.
REQ-034 out_ready held low for 10 cycles -> outputs frozen, overrun=1, index not advanced; release -> transfer, then normal scanning with overrun still 1.
REQ-035 out_ready rises exactly on a dwell-wrap cycle -> overrun stays 0, next digit presented back-to-back; rst pulsed while out_valid=1 -> out_valid=0 the next cycle, digit 0 presented first after release.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, types and hex decode table for seg_scan_buffer
//
// Purpose: segment bit positions, 16-entry hex-to-segment table, blank pattern,
//          the ASCII control bytes the buffer reacts to, the scanner state type
//          and a helper that classifies a received byte as a hex digit.
// Ports:   none (package).
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] HEX_SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_DOT = 8'h2E;

  typedef enum logic {
    ST_SCAN    = 1'b0,
    ST_PRESENT = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } hex_char_t;

  // Accepts '0'-'9', 'A'-'F' and 'a'-'f'; anything else comes back invalid.
  function automatic hex_char_t ascii_to_hex(input logic [7:0] b);
    hex_char_t r;
    r.valid = 1'b0;
    r.value = 4'h0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r.valid = 1'b1;
      r.value = 4'(b - 8'h30);
    end else if (b >= 8'h41 && b <= 8'h46) begin
      r.valid = 1'b1;
      r.value = 4'(b - 8'h37);
    end else if (b >= 8'h61 && b <= 8'h66) begin
      r.valid = 1'b1;
      r.value = 4'(b - 8'h57);
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational buffer-entry to seven-segment decoder
//
// Purpose: turn one buffer entry into an active-high segment pattern.
// Ports:   used    - entry holds a digit; when low the digit is blank
//          nibble  - hex value 0..F
//          dp      - decimal point, applied even on a blank digit
//          pattern - bit0=a .. bit6=g, bit7=dp
module hex_to_seg
  import seg_pkg::*;
(
  input  logic       used,
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern         = used ? HEX_SEG_TABLE[nibble] : SEG_BLANK;
    pattern[SEG_DP] = pattern[SEG_DP] | dp;
  end

endmodule

// File: rtl/seg_scan_buffer.sv
// rtl/seg_scan_buffer.sv - UART-fed hex digit buffer with handshaked digit scanner
//
// Purpose: collect ASCII hex digits / '.' / CR into a DIGITS-entry shift buffer
//          and present one digit per dwell period to a downstream driver.
// Ports:   sys_clk   - clock, rising edge
//          rst       - synchronous active-high reset
//          rx_data   - received ASCII byte, qualified by rx_valid
//          rx_valid  - one-cycle strobe
//          segments  - pattern of the presented digit (bit7 = dp)
//          digit_sel - one-hot enable of the presented digit
//          out_valid - segments/digit_sel carry a digit not yet accepted
//          out_ready - downstream accepts when high together with out_valid
//          overrun   - sticky: a dwell expired with a presentation pending
module seg_scan_buffer
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SYSCLK_F = 24000000,
  parameter int SCAN_HZ  = 800
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        segments,
  output logic [DIGITS-1:0] digit_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int DWELL_CYC = SYSCLK_F / (SCAN_HZ * DIGITS);
  localparam int DW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int IW        = $clog2(DIGITS);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Digit buffer, index 0 is the rightmost digit.
  logic       r_used [DIGITS];
  logic [3:0] r_nib  [DIGITS];
  logic       r_dp   [DIGITS];

  logic [DW-1:0]     r_dwell;
  logic [IW-1:0]     r_idx;
  scan_state_t       r_state;
  logic [7:0]        r_segments;
  logic [DIGITS-1:0] r_digit_sel;
  logic              r_out_valid;
  logic              r_overrun;

  hex_char_t         w_hex;
  logic              w_wrap;
  logic              w_xfer;
  logic [IW-1:0]     w_next_idx;
  logic [7:0]        w_pattern;
  logic [DIGITS-1:0] w_sel;
  scan_state_t       w_state_nx;
  logic              w_load;
  logic              w_drop;
  logic              w_set_overrun;

  assign w_hex      = ascii_to_hex(rx_data);
  assign w_wrap     = (r_dwell == DWELL_LAST);
  assign w_xfer     = r_out_valid & out_ready;
  assign w_next_idx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  assign w_sel      = DIGITS'(1) << w_next_idx;

  // Reads the registered buffer, so a load coinciding with a write sees the
  // pre-write contents.
  hex_to_seg u_hex_to_seg (
    .used    (r_used[w_next_idx]),
    .nibble  (r_nib[w_next_idx]),
    .dp      (r_dp[w_next_idx]),
    .pattern (w_pattern)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_used[i] <= 1'b0;
        r_nib[i]  <= 4'h0;
        r_dp[i]   <= 1'b0;
      end
    end else if (rx_valid) begin
      if (w_hex.valid) begin
        for (int i = DIGITS - 1; i > 0; i--) begin
          r_used[i] <= r_used[i-1];
          r_nib[i]  <= r_nib[i-1];
          r_dp[i]   <= r_dp[i-1];
        end
        r_used[0] <= 1'b1;
        r_nib[0]  <= w_hex.value;
        r_dp[0]   <= 1'b0;
      end else if (rx_data == ASCII_DOT) begin
        r_dp[0] <= 1'b1;
      end else if (rx_data == ASCII_CR) begin
        for (int i = 0; i < DIGITS; i++) begin
          r_used[i] <= 1'b0;
          r_nib[i]  <= 4'h0;
          r_dp[i]   <= 1'b0;
        end
      end
    end
  end

  // Dwell timer free-runs regardless of the handshake.
  always_ff @(posedge sys_clk) begin
    if (rst)         r_dwell <= '0;
    else if (w_wrap) r_dwell <= '0;
    else             r_dwell <= r_dwell + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= ST_SCAN;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_load        = 1'b0;
    w_drop        = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_wrap) begin
          w_load     = 1'b1;
          w_state_nx = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (w_xfer) begin
          // Acceptance on the wrap cycle is on time: chain straight into the
          // next digit without leaving PRESENT.
          if (w_wrap) begin
            w_load = 1'b1;
          end else begin
            w_drop     = 1'b1;
            w_state_nx = ST_SCAN;
          end
        end else if (w_wrap) begin
          w_set_overrun = 1'b1;
        end
      end
      default: w_state_nx = ST_SCAN;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_idx       <= IDX_LAST;
      r_segments  <= SEG_BLANK;
      r_digit_sel <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_idx       <= w_next_idx;
        r_segments  <= w_pattern;
        r_digit_sel <= w_sel;
        r_out_valid <= 1'b1;
      end else if (w_drop) begin
        r_out_valid <= 1'b0;
      end
      if (w_set_overrun) r_overrun <= 1'b1;
    end
  end

  assign segments  = r_segments;
  assign digit_sel = r_digit_sel;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule
